// File: rtl/idex_hazard_ctrl_pkg.sv
// rtl/idex_hazard_ctrl_pkg.sv - shared types and constants for the pipeline sequencing controller
package idex_hazard_ctrl_pkg;

  localparam int REG_ID_W = 3;

  // Opcode field the IF/ID latch loads when flushed.
  localparam logic [4:0] NOP_OPCODE = 5'b00001;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic memwb_en;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PC_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctrl_t PC_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam pipe_ctrl_t PC_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t PC_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t PC_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam pipe_ctrl_t PC_DRAIN  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

endpackage

// File: rtl/idex_hazard_ctrl_sat_counter.sv
// rtl/idex_hazard_ctrl_sat_counter.sv - width-parameterised saturating up-counter with sync clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_n_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/idex_hazard_ctrl.sv
// rtl/idex_hazard_ctrl.sv - PC/IF/ID/EX/MEM/WB latch sequencing: load-use stall, mem freeze, flush, halt
module idex_hazard_ctrl
  import idex_hazard_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ID_W-1:0] id_rs,
  input  logic [REG_ID_W-1:0] id_rt,
  input  logic                id_use_rs,
  input  logic                id_use_rt,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic [REG_ID_W-1:0] ex_rd,
  input  logic                ex_branch_taken,
  input  logic                ex_halt,
  input  logic                mem_busy,
  output logic                pc_en,
  output logic                ifid_en,
  output logic                ifid_flush,
  output logic                idex_en,
  output logic                idex_bubble,
  output logic                exmem_en,
  output logic                memwb_en,
  output logic [1:0]          ctrl_state,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [1:0] LU_LOAD = 2'(LU_STALL_CYCLES - 1);
  localparam bit         LU_MULTI = (LU_STALL_CYCLES > 1);

  ctrl_state_e state_q, state_d;
  logic [1:0]  lu_cnt_q, lu_cnt_d;
  pipe_ctrl_t  ctrl;
  logic        hazard;

  assign hazard = ex_valid & ex_mem_read &
                  ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  always_comb begin
    ctrl     = PC_RUN;
    state_d  = state_q;
    lu_cnt_d = lu_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          ctrl    = PC_FREEZE;
          state_d = ST_MEM_WAIT;
        end else if (ex_halt) begin
          ctrl    = PC_BUBBLE;
          state_d = ST_HALTED;
        end else if (ex_branch_taken) begin
          ctrl = PC_BRANCH;
        end else if (hazard) begin
          ctrl     = PC_BUBBLE;
          lu_cnt_d = LU_LOAD;
          state_d  = LU_MULTI ? ST_LU_STALL : ST_RUN;
        end
      end
      ST_LU_STALL: begin
        if (mem_busy) begin
          ctrl    = PC_FREEZE;
          state_d = ST_MEM_WAIT;
        end else if (ex_halt) begin
          ctrl     = PC_BUBBLE;
          lu_cnt_d = 2'd0;
          state_d  = ST_HALTED;
        end else if (ex_branch_taken) begin
          // The bubbled instruction is on the wrong path anyway; drop the rest of the stall.
          ctrl     = PC_BRANCH;
          lu_cnt_d = 2'd0;
          state_d  = ST_RUN;
        end else begin
          ctrl     = PC_BUBBLE;
          lu_cnt_d = lu_cnt_q - 2'd1;
          if (lu_cnt_q <= 2'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          ctrl = PC_FREEZE;
        end else begin
          ctrl    = PC_RUN;
          state_d = (lu_cnt_q != 2'd0) ? ST_LU_STALL : ST_RUN;
        end
      end
      default: begin
        ctrl = PC_DRAIN;
      end
    endcase
    if (!rst) begin
      ctrl = PC_RESET;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      lu_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_bubble = ctrl.idex_bubble;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ctrl_state  = rst ? state_q : ST_RUN;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk),
    .clr_n_i (rst),
    .inc_i   (~ctrl.pc_en),
    .count_o (stall_cnt)
  );

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// tb/tb_idex_hazard_ctrl.sv - directed-vector bench; instance a: 1 bubble/16-bit count, b: 2 bubbles/4-bit count
module tb_idex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_valid, ex_mem_read;
  logic       ex_branch_taken, ex_halt, mem_busy;

  logic       a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble, a_exmem_en, a_memwb_en;
  logic       b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble, b_exmem_en, b_memwb_en;
  logic [1:0] a_state, b_state;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Pattern order: pc, ifid_en, ifid_flush, idex_en, idex_bubble, exmem, memwb
  localparam logic [6:0] P_RST = 7'b0010100;
  localparam logic [6:0] P_RUN = 7'b1101011;
  localparam logic [6:0] P_FRZ = 7'b0000000;
  localparam logic [6:0] P_BUB = 7'b0001111;
  localparam logic [6:0] P_BR  = 7'b1111111;
  localparam logic [6:0] P_HLT = 7'b0000011;

  wire [6:0] a_pipe = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_bubble, a_exmem_en, a_memwb_en};
  wire [6:0] b_pipe = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_bubble, b_exmem_en, b_memwb_en};

  always #5 clk = ~clk;

  idex_hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_halt(ex_halt), .mem_busy(mem_busy), .pc_en(a_pc_en), .ifid_en(a_ifid_en),
    .ifid_flush(a_ifid_flush), .idex_en(a_idex_en), .idex_bubble(a_idex_bubble),
    .exmem_en(a_exmem_en), .memwb_en(a_memwb_en), .ctrl_state(a_state), .stall_cnt(a_cnt)
  );

  idex_hazard_ctrl #(.LU_STALL_CYCLES(2), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .ex_halt(ex_halt), .mem_busy(mem_busy), .pc_en(b_pc_en), .ifid_en(b_ifid_en),
    .ifid_flush(b_ifid_flush), .idex_en(b_idex_en), .idex_bubble(b_idex_bubble),
    .exmem_en(b_exmem_en), .memwb_en(b_memwb_en), .ctrl_state(b_state), .stall_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_pipe(input string tag, input logic [6:0] pa, input logic [1:0] sa,
                             input logic [6:0] pb, input logic [1:0] sb);
    check({tag, ".a.pipe"},  32'(a_pipe),  32'(pa));
    check({tag, ".a.state"}, 32'(a_state), 32'(sa));
    check({tag, ".b.pipe"},  32'(b_pipe),  32'(pb));
    check({tag, ".b.state"}, 32'(b_state), 32'(sb));
  endtask

  task automatic expect_cnt(input string tag, input int ca, input int cb);
    check({tag, ".a.cnt"}, 32'(a_cnt), 32'(ca));
    check({tag, ".b.cnt"}, 32'(b_cnt), 32'(cb));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_rs = 3'd0; id_rt = 3'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_rd = 3'd0;
    ex_branch_taken = 1'b0; ex_halt = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_hazard;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd3; id_use_rt = 1'b1; id_rt = 3'd3;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    tick();
    tick();
    expect_pipe("reset", P_RST, 2'd0, P_RST, 2'd0);
    expect_cnt("reset", 0, 0);

    rst = 1'b1;
    #1;
    expect_pipe("release", P_RUN, 2'd0, P_RUN, 2'd0);
    tick();

    // load-use on rt: a bubbles once, b bubbles twice
    set_hazard();
    #1;
    expect_pipe("lu.c0", P_BUB, 2'd0, P_BUB, 2'd0);
    tick();
    ex_valid = 1'b0;
    #1;
    expect_pipe("lu.c1", P_RUN, 2'd0, P_BUB, 2'd1);
    tick();
    expect_pipe("lu.c2", P_RUN, 2'd0, P_RUN, 2'd0);
    expect_cnt("lu", 1, 2);

    // matching rt but not used, rs differs: no hazard
    set_hazard();
    id_use_rt = 1'b0; id_use_rs = 1'b1; id_rs = 3'd5;
    #1;
    expect_pipe("nouse", P_RUN, 2'd0, P_RUN, 2'd0);
    tick();
    // rs matches but EX holds a bubble
    id_rs = 3'd3; ex_valid = 1'b0;
    #1;
    expect_pipe("exbub", P_RUN, 2'd0, P_RUN, 2'd0);
    tick();
    idle();

    // branch coincident with hazard: flush wins, no stall
    set_hazard();
    ex_branch_taken = 1'b1;
    #1;
    expect_pipe("br+lu", P_BR, 2'd0, P_BR, 2'd0);
    tick();
    idle();
    #1;
    expect_pipe("br.after", P_RUN, 2'd0, P_RUN, 2'd0);
    expect_cnt("br", 1, 2);
    tick();

    // mem_busy 3 cycles while b is in LU_STALL
    set_hazard();
    #1;
    expect_pipe("mw.c0", P_BUB, 2'd0, P_BUB, 2'd0);
    tick();
    idle();
    mem_busy = 1'b1;
    #1;
    expect_pipe("mw.c1", P_FRZ, 2'd0, P_FRZ, 2'd1);
    tick();
    expect_pipe("mw.c2", P_FRZ, 2'd2, P_FRZ, 2'd2);
    tick();
    expect_pipe("mw.c3", P_FRZ, 2'd2, P_FRZ, 2'd2);
    tick();
    mem_busy = 1'b0;
    #1;
    expect_pipe("mw.c4", P_RUN, 2'd2, P_RUN, 2'd2);
    tick();
    expect_pipe("mw.c5", P_RUN, 2'd0, P_BUB, 2'd1);
    tick();
    expect_pipe("mw.c6", P_RUN, 2'd0, P_RUN, 2'd0);
    expect_cnt("mw", 5, 7);

    // branch taken while b sits in LU_STALL
    set_hazard();
    #1;
    tick();
    idle();
    ex_branch_taken = 1'b1;
    #1;
    expect_pipe("lubr.c1", P_BR, 2'd0, P_BR, 2'd1);
    tick();
    idle();
    #1;
    expect_pipe("lubr.c2", P_RUN, 2'd0, P_RUN, 2'd0);
    expect_cnt("lubr", 6, 8);

    // halt: park, drain, count saturates in the 4-bit instance
    ex_valid = 1'b1; ex_halt = 1'b1;
    #1;
    expect_pipe("halt.c0", P_BUB, 2'd0, P_BUB, 2'd0);
    tick();
    idle();
    #1;
    expect_pipe("halt.c1", P_HLT, 2'd3, P_HLT, 2'd3);
    tick();
    ex_branch_taken = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    expect_pipe("halt.park", P_HLT, 2'd3, P_HLT, 2'd3);
    expect_cnt("halt", 18, 15);
    idle();

    // reset out of HALTED
    rst = 1'b0;
    #1;
    expect_pipe("rst2", P_RST, 2'd0, P_RST, 2'd0);
    tick();
    expect_cnt("rst2", 0, 0);
    rst = 1'b1;
    #1;
    expect_pipe("rst2.rel", P_RUN, 2'd0, P_RUN, 2'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/idex_hazard_ctrl.md
Name: idex_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives the write-enables and bubble/flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Detects load-use hazards against the ID/EX latch contents, freezes the pipe during data-memory busy, flushes on taken branches resolved in EX, and parks the pipe on HALT.
- Sits beside the decode stage; it reads decoded register specifiers from ID and control bits already captured in ID/EX.

Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1 with MEM->EX forwarding, 2 without); legal range 1..3.
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset; sampled on rising clk.
- id_rs  in  3  source register A of the instruction in ID.
- id_rt  in  3  source register B of the instruction in ID.
- id_use_rs  in  1  ID instruction reads id_rs.
- id_use_rt  in  1  ID instruction reads id_rt.
- ex_valid  in  1  ID/EX latch holds a real instruction, not a bubble.
- ex_mem_read  in  1  ID/EX instruction is a load (MemToReg set, DMemWrite clear).
- ex_rd  in  3  destination register of the ID/EX instruction.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- ex_halt  in  1  ID/EX instruction is HALT (DMemDump).
- mem_busy  in  1  data memory cannot complete this cycle.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID latch enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_en  out  1  ID/EX latch enable.
- idex_bubble  out  1  zero all ID/EX control inputs (RegWrite, DMemWrite, MemToReg, DMemDump) this load.
- exmem_en  out  1  EX/MEM latch enable.
- memwb_en  out  1  MEM/WB latch enable.
- ctrl_state  out  2  current FSM state, for debug.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0 since reset.

Behaviour:
- States: RUN=0, LU_STALL=1, MEM_WAIT=2, HALTED=3. All outputs are combinational from the state and current inputs (Mealy); only the state, the bubble counter lu_cnt and stall_cnt are registered.
- Reset: rst=0 at an edge forces state=RUN, lu_cnt=0, stall_cnt=0. While rst=0:
  - all *_en=0;
  - ifid_flush=1 and idex_bubble=1;
  - ctrl_state=0.
- hazard = ex_valid & ex_mem_read & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- Priority (highest first): mem_busy, ex_halt, ex_branch_taken, hazard.
- RUN:
  - mem_busy: all enables 0; next MEM_WAIT.
  - ex_halt: pc_en=0, ifid_en=0, idex_en=1 with idex_bubble=1, exmem_en=1, memwb_en=1; next HALTED.
  - ex_branch_taken: all enables 1, ifid_flush=1, idex_bubble=1; stay RUN. A coincident hazard is discarded.
  - hazard: pc_en=0, ifid_en=0, idex_en=1 with idex_bubble=1, downstream enables 1. lu_cnt loads LU_STALL_CYCLES-1. Next state is LU_STALL if LU_STALL_CYCLES>1, else RUN.
  - otherwise: all enables 1, no flush or bubble.
- LU_STALL:
  - Outputs are the same as for a hazard in RUN; lu_cnt decrements each cycle.
  - Next RUN when lu_cnt reaches 1.
  - mem_busy overrides: go to MEM_WAIT with lu_cnt held, and resume LU_STALL on exit.
  - ex_branch_taken in LU_STALL takes the branch action and returns to RUN.
- MEM_WAIT:
  - All enables 0, no flush or bubble.
  - On the first cycle with mem_busy=0: enables as in RUN/no-hazard. Next RUN, or LU_STALL if lu_cnt≠0.
- HALTED:
  - pc_en=0, ifid_en=0, idex_en=0.
  - exmem_en=1 and memwb_en=1 so in-flight instructions drain.
  - Exit only by reset.
- stall_cnt increments on every cycle with pc_en=0 and rst=1, including HALTED and MEM_WAIT. It saturates at all-ones.
- Reset mid-stall or mid-MEM_WAIT abandons all pending state; there is no replay.

Decomposition:
- Shared package holds:
  - state encodings RUN/LU_STALL/MEM_WAIT/HALTED;
  - REG_ID_W=3;
  - the NOP opcode used by the IF/ID flush path.
- One natural sub-module: sat_counter (width-parameterised, sync active-low clear, increment enable, saturating), used for stall_cnt.
- The hazard comparator stays inline.

Test Plan:
- Reset: rst=0 for 2 cycles → all *_en=0, ifid_flush=1, idex_bubble=1, stall_cnt=0; first cycle after release → ctrl_state=0, all *_en=1.
- Load-use, LU_STALL_CYCLES=1: ex_valid=1, ex_mem_read=1, ex_rd=3, id_use_rt=1, id_rt=3 → exactly one cycle of pc_en=0, idex_bubble=1, then RUN; stall_cnt=1.
- Load-use, LU_STALL_CYCLES=2, same stimulus → two bubble cycles (ctrl_state 1 then 0); a hazard with id_use_rt=0 gives no stall.
- Branch plus hazard in the same cycle → ifid_flush=1, idex_bubble=1, pc_en=1; no LU_STALL entered.
- mem_busy for 3 cycles during LU_STALL (param 2) → 3 cycles all *_en=0 in MEM_WAIT, then remaining 1 bubble cycle, then RUN; stall_cnt increases by 4.
- ex_halt=1 → HALTED, pc_en=0 permanently, exmem_en=memwb_en=1; stall_cnt saturates at 0xFFFF with CNT_W=16 after 65535+ cycles (shorten via CNT_W=4 → 15).
